// File: rtl/cpu_defs.sv
// cpu_defs -- shared CPU front-end definitions.
//   fetch_entry_t  : one fetched instruction as carried from fetch to decode
//   DISPATCH_DEPTH : default entry count of the decode dispatch queue
package cpu_defs;

  localparam int DISPATCH_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_cf;    // branch/jump with an architectural delay slot
    logic        is_priv;  // privileged op (e.g. MTC0); must issue alone
  } fetch_entry_t;

endpackage

// File: rtl/decode_dispatch_if.sv
// decode_dispatch_if -- fetch-side push bus and decoder-side issue bus of the
// decode dispatch queue, plus flush and occupancy.
//   slave  : the dispatch queue (takes pushes, offers issues)
//   master : the surrounding front end / backend
// Params: DEPTH (queue entries, sizes occupancy).
interface decode_dispatch_if
  import cpu_defs::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) ();

  logic                     flush;
  logic [1:0]               push_valid;
  fetch_entry_t [1:0]       push_entry;
  logic                     push_ready;
  logic [1:0]               issue_valid;
  fetch_entry_t [1:0]       issue_entry;
  logic [1:0]               issue_ready;
  logic [$clog2(DEPTH):0]   occupancy;

  modport slave (
    input  flush, push_valid, push_entry, issue_ready,
    output push_ready, issue_valid, issue_entry, occupancy
  );

  modport master (
    output flush, push_valid, push_entry, issue_ready,
    input  push_ready, issue_valid, issue_entry, occupancy
  );

endinterface

// File: rtl/dispatch_fifo.sv
// dispatch_fifo -- circular storage for the dispatch queue.
// 2-wide push at tail, 0/1/2 pop at head, synchronous flush.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   flush         : empty the queue next cycle (push/pop ignored)
//   push_en[1:0]  : slot write enables (slot1 only with slot0), pre-qualified
//   push_entry    : slot data, slot0 written at tail, slot1 at tail+1
//   pop_cnt       : entries retired from head this cycle (<= count)
//   head_entry    : [0] = head, [1] = head+1
//   count         : current entry count
module dispatch_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               push_en,
  input  fetch_entry_t [1:0]       push_entry,
  input  logic [1:0]               pop_cnt,
  output fetch_entry_t [1:0]       head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head, tail, head_nx, tail_nx;
  logic [1:0]    push_cnt;

  // pointers wrap for free since DEPTH is a power of two
  assign head_nx  = head + AW'(1);
  assign tail_nx  = tail + AW'(1);
  assign push_cnt = {1'b0, push_en[0]} + {1'b0, push_en[1]};

  assign head_entry[0] = mem[head];
  assign head_entry[1] = mem[head_nx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // storage is cleared so the offered entries read as zero out of reset
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_en[0]) mem[tail]    <= push_entry[0];
      if (push_en[1]) mem[tail_nx] <= push_entry[1];
      tail  <= tail + AW'(push_cnt);
      head  <= head + AW'(pop_cnt);
      count <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

endmodule

// File: rtl/decode_dispatch.sv
// decode_dispatch -- instruction queue between fetch and the two decoders.
// Fetch pushes up to two entries per cycle; the head of the queue is offered
// combinationally to decoder lane0 (head) and lane1 (head+1).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : decode_dispatch_if.slave (flush, push_*, issue_*, occupancy)
// Params: DEPTH (power of two, >= 4).
// Config macro: DECODE_DUAL_ISSUE_EN
//   defined   -> lane1 may issue; a control-flow head waits for its delay
//                slot and both retire together; privileged ops issue alone
//   undefined -> single issue on lane0 only, control flow included (its
//                delay slot follows next cycle); lane1 never valid
module decode_dispatch
  import cpu_defs::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  decode_dispatch_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  // push_ready needs room for a full 2-wide push, judged on pre-pop count
  localparam logic [CW-1:0] PUSH_MAX = CW'(DEPTH - 2);

  fetch_entry_t [1:0] head_e;
  logic [CW-1:0]      count;
  logic [1:0]         push_en;
  logic [1:0]         pop_cnt;
  logic               v0, v1;
  logic               has1, has2;

  dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.flush),
    .push_en    (push_en),
    .push_entry (bus.push_entry),
    .pop_cnt    (pop_cnt),
    .head_entry (head_e),
    .count      (count)
  );

  assign bus.push_ready = (count <= PUSH_MAX);
  assign push_en[0]     = bus.push_valid[0] & bus.push_ready & ~bus.flush;
  assign push_en[1]     = bus.push_valid[1] & push_en[0];

  assign has1 = (count != '0);
  assign has2 = (count >= CW'(2));

`ifdef DECODE_DUAL_ISSUE_EN
  logic paired;

  always_comb begin
    paired  = head_e[0].is_cf;
    // a branch at head is held until its delay slot is also queued
    v0      = ~bus.flush & has1 & ~(paired & ~has2);
    // the delay slot of a paired head may itself be control flow
    v1      = ~bus.flush & has2 & ~head_e[0].is_priv & ~head_e[1].is_priv
              & (paired | ~head_e[1].is_cf);
    pop_cnt = 2'd0;
    if (paired) begin
      // branch and delay slot leave as one unit or not at all
      if (v1 & bus.issue_ready[0] & bus.issue_ready[1]) pop_cnt = 2'd2;
    end else begin
      pop_cnt = {1'b0, v0 & bus.issue_ready[0]}
              + {1'b0, v1 & bus.issue_ready[0] & bus.issue_ready[1]};
    end
  end
`else
  logic unused_lane1;
  assign unused_lane1 = bus.issue_ready[1];

  always_comb begin
    v0      = ~bus.flush & has1;
    v1      = 1'b0;
    pop_cnt = {1'b0, v0 & bus.issue_ready[0]};
  end
`endif

  assign bus.issue_valid = {v1, v0};
  assign bus.issue_entry = head_e;
  assign bus.occupancy   = count;

endmodule

// File: tb/tb_decode_dispatch.sv
// tb_decode_dispatch -- directed bench for decode_dispatch (DEPTH=8).
// A scoreboard queue models queue contents: pushes are appended when the
// bench drives them, offered entries are compared against its front as they
// retire. Builds with or without DECODE_DUAL_ISSUE_EN.
module tb_decode_dispatch;
  import cpu_defs::*;

  localparam int DEPTH = 8;
`ifdef DECODE_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_dispatch_if #(.DEPTH(DEPTH)) bus ();

  decode_dispatch #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_entry_t q[$];
  fetch_entry_t nop_e;
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc, input logic cf, input logic priv);
    fetch_entry_t e;
    e.pc      = pc;
    e.instr   = pc ^ 32'h0085_1021;
    e.is_cf   = cf;
    e.is_priv = priv;
    return e;
  endfunction

  // expected offer / retire for a queue holding only plain ALU ops
  function automatic logic [1:0] iv_plain(input int n);
    if (n == 0) return 2'b00;
    if (DUAL && n >= 2) return 2'b11;
    return 2'b01;
  endfunction

  function automatic int pop_plain(input int n, input logic [1:0] ir);
    if (!ir[0] || n == 0) return 0;
    if (DUAL && n >= 2 && ir[1]) return 2;
    return 1;
  endfunction

  // one cycle: drive after negedge, check offer, clock, update model, check count
  task automatic step(input logic [1:0] pv, input fetch_entry_t e0, input fetch_entry_t e1,
                      input logic [1:0] ir, input logic fl,
                      input logic [1:0] exp_iv, input int exp_pop, input string tag);
    logic exp_pr;
    bus.push_valid    = pv;
    bus.push_entry[0] = e0;
    bus.push_entry[1] = e1;
    bus.issue_ready   = ir;
    bus.flush         = fl;
    #1;
    exp_pr = (DEPTH - q.size()) >= 2;
    chk({tag, ".iv"}, 96'(bus.issue_valid), 96'(exp_iv));
    chk({tag, ".pr"}, 96'(bus.push_ready), 96'(exp_pr));
    for (int i = 0; i < exp_pop; i++)
      chk($sformatf("%s.lane%0d", tag, i), 96'(bus.issue_entry[i]), 96'(q[i]));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      repeat (exp_pop) void'(q.pop_front());
      if (exp_pr && pv[0]) begin
        q.push_back(e0);
        if (pv[1]) q.push_back(e1);
      end
    end
    @(negedge clk);
    bus.push_valid  = 2'b00;
    bus.issue_ready = 2'b00;
    bus.flush       = 1'b0;
    chk({tag, ".occ"}, 96'(bus.occupancy), 96'(q.size()));
  endtask

  initial begin
    nop_e           = mk(32'h0, 1'b0, 1'b0);
    rst_n           = 1'b0;
    bus.flush       = 1'b0;
    bus.push_valid  = 2'b00;
    bus.push_entry  = '0;
    bus.issue_ready = 2'b00;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.occ", 96'(bus.occupancy), 96'(0));
    chk("rst.iv", 96'(bus.issue_valid), 96'(0));
    chk("rst.pr", 96'(bus.push_ready), 96'(1));
    chk("rst.entry", 96'(bus.issue_entry), 96'(0));
    rst_n = 1'b1;

    // reset asserted in the middle of a 2-entry push
    step(2'b11, mk(32'h10, 1'b0, 1'b0), mk(32'h14, 1'b0, 1'b0), 2'b00, 1'b0, 2'b00, 0, "pre_rst");
    bus.push_valid    = 2'b11;
    bus.push_entry[0] = mk(32'h18, 1'b0, 1'b0);
    bus.push_entry[1] = mk(32'h1c, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.occ", 96'(bus.occupancy), 96'(0));
    chk("mid_rst.iv", 96'(bus.issue_valid), 96'(0));
    chk("mid_rst.pr", 96'(bus.push_ready), 96'(1));
    bus.push_valid = 2'b00;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, nop_e, nop_e, 2'b11, 1'b0, 2'b00, 0, "post_rst");

    // dual issue of two ALU ops
    step(2'b11, mk(32'h100, 1'b0, 1'b0), mk(32'h104, 1'b0, 1'b0), 2'b11, 1'b0, 2'b00, 0, "dual_push");
    step(2'b00, nop_e, nop_e, 2'b11, 1'b0, DUAL ? 2'b11 : 2'b01, DUAL ? 2 : 1, "dual_issue");
    step(2'b00, nop_e, nop_e, 2'b11, 1'b0, DUAL ? 2'b00 : 2'b01, DUAL ? 0 : 1, "dual_tail");

    // branch + delay slot
    step(2'b01, mk(32'h200, 1'b1, 1'b0), nop_e, 2'b00, 1'b0, 2'b00, 0, "br_push");
    step(2'b01, mk(32'h204, 1'b0, 1'b0), nop_e, 2'b00, 1'b0, DUAL ? 2'b00 : 2'b01, 0, "ds_push");
    step(2'b00, nop_e, nop_e, 2'b01, 1'b0, DUAL ? 2'b11 : 2'b01, DUAL ? 0 : 1, "br_half");
    step(2'b00, nop_e, nop_e, 2'b11, 1'b0, DUAL ? 2'b11 : 2'b01, DUAL ? 2 : 1, "br_both");

    // privileged head serialises
    step(2'b11, mk(32'h300, 1'b0, 1'b1), mk(32'h304, 1'b0, 1'b0), 2'b00, 1'b0, 2'b00, 0, "priv_push");
    step(2'b00, nop_e, nop_e, 2'b11, 1'b0, 2'b01, 1, "priv_issue");
    step(2'b00, nop_e, nop_e, 2'b11, 1'b0, 2'b01, 1, "after_priv");

    // fill to full, dropped push, drain, refill across the wrap, drain
    for (int k = 0; k < 4; k++)
      step(2'b11, mk(32'h400 + 32'(16 * k), 1'b0, 1'b0), mk(32'h408 + 32'(16 * k), 1'b0, 1'b0),
           2'b00, 1'b0, iv_plain(q.size()), 0, "fill");
    step(2'b11, mk(32'h480, 1'b0, 1'b0), mk(32'h484, 1'b0, 1'b0), 2'b00, 1'b0, iv_plain(8), 0, "drop");
    for (int k = 0; k < 8; k++)
      step(2'b00, nop_e, nop_e, 2'b11, 1'b0, iv_plain(q.size()), pop_plain(q.size(), 2'b11), "drain");
    for (int k = 0; k < 4; k++)
      step(2'b11, mk(32'h500 + 32'(16 * k), 1'b0, 1'b0), mk(32'h508 + 32'(16 * k), 1'b0, 1'b0),
           2'b00, 1'b0, iv_plain(q.size()), 0, "refill");
    for (int k = 0; k < 8; k++)
      step(2'b00, nop_e, nop_e, 2'b11, 1'b0, iv_plain(q.size()), pop_plain(q.size(), 2'b11), "redrain");

    // flush with coincident push and ready
    step(2'b11, mk(32'h600, 1'b0, 1'b0), mk(32'h604, 1'b0, 1'b0), 2'b00, 1'b0, iv_plain(q.size()), 0, "fl_fill");
    step(2'b11, mk(32'h608, 1'b0, 1'b0), mk(32'h60c, 1'b0, 1'b0), 2'b00, 1'b0, iv_plain(q.size()), 0, "fl_fill");
    step(2'b01, mk(32'h610, 1'b0, 1'b0), nop_e, 2'b00, 1'b0, iv_plain(q.size()), 0, "fl_fill");
    step(2'b11, mk(32'h700, 1'b0, 1'b0), mk(32'h704, 1'b0, 1'b0), 2'b11, 1'b1, 2'b00, 0, "flush");
    step(2'b00, nop_e, nop_e, 2'b11, 1'b0, 2'b00, 0, "post_flush");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_dispatch.md
DECODE_DISPATCH -- requirements
Module: decode_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries (power of two, >=4).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  discard all queued entries (mispredict/exception).
REQ-005 SHALL have port push_valid  input  2  per-slot fetch valid; slot1 valid only with slot0.
REQ-006 SHALL have port push_entry  input  2 x fetch_entry_t  {pc[31:0], instr[31:0], is_cf, is_priv}.
REQ-007 SHALL have port push_ready  output  1  free entries >= 2.
REQ-008 SHALL have port issue_valid  output  2  per-lane entry offered to the decoders.
REQ-009 SHALL have port issue_entry  output  2 x fetch_entry_t  lane0 = head, lane1 = head+1.
REQ-010 SHALL have port issue_ready  input  2  backend accepts lane; lane1 ready ignored unless lane0 ready.
REQ-011 SHALL have port occupancy  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-012 SHALL store entries in a circular buffer; head/tail pointers wrap modulo DEPTH.
REQ-013 SHALL write push slot0 then slot1 at tail when push_ready=1; push when push_ready=0 SHALL be dropped.
REQ-014 SHALL drive issue outputs combinationally from queue state; zero-latency offer, push-to-offer latency 1 cycle.
REQ-015 SHALL assert issue_valid[0] when occupancy>=1, except when head is_cf=1 and occupancy<2 (delay slot not yet queued).
REQ-016 SHALL assert issue_valid[1] only when occupancy>=2, head is_priv=0, head+1 is_priv=0, and head+1 is_cf=0.
REQ-017 SHALL treat head is_cf=1 as paired: lane0 and lane1 (delay slot) retire together, and lane1 is_cf is not checked in this case.
REQ-018 SHALL pop n = issue_valid[0]&issue_ready[0] + issue_valid[1]&issue_ready[1]&issue_ready[0]; a paired head SHALL pop 0 unless both ready.
REQ-019 SHALL update occupancy = occupancy + pushed - popped in the same cycle when push and pop coincide; push into an entry freed this cycle is not required (push_ready uses pre-pop count).
REQ-020 SHALL, on flush, set head=tail=occupancy=0 next cycle, ignore same-cycle push and pop, and deassert issue_valid that cycle.
REQ-021 SHALL never pop beyond occupancy nor push beyond DEPTH.

Reset
REQ-022 SHALL, while rst_n=0, hold head=0, tail=0, occupancy=0, issue_valid=0, push_ready=1, issue_entry=0.
REQ-023 SHALL take effect asynchronously on rst_n fall and release cleanly on the first clk edge after rst_n rise, including mid-transfer.

Configuration
REQ-024 SHALL honour macro DECODE_DUAL_ISSUE_EN: defined -> REQ-016/017 dual-lane behaviour.
REQ-025 SHALL, without DECODE_DUAL_ISSUE_EN, tie issue_valid[1]=0, issue lane0 alone including control flow (delay slot follows next cycle), and ignore REQ-015 is_cf exception.

Structure
REQ-026 SHALL place fetch_entry_t and DISPATCH_DEPTH default in the shared cpu_defs package.
REQ-027 SHALL implement storage/pointers in sub-module dispatch_fifo (2-wide push, 0/1/2 pop, flush); dispatch rules stay in decode_dispatch.

Verification
REQ-028 Reset: rst_n=0 mid-push of 2 entries -> occupancy=0, issue_valid=00, push_ready=1.
REQ-029 Dual issue: push ADDU pc 0x100, ADDU pc 0x104, issue_ready=11 -> next cycle issue_valid=11, both popped, occupancy 2->0.
REQ-030 Delay slot: push only BEQ (is_cf) pc 0x200 -> issue_valid=00; push delay slot next cycle -> issue_valid=11; issue_ready=01 -> no pop, occupancy stays 2.
REQ-031 Serialisation: head MTC0 (is_priv) + ADDU -> issue_valid=01; after pop ADDU offered in lane0.
REQ-032 Full/wrap: DEPTH=8, 4 pushes of 2 with no issue -> push_ready=0, 5th push dropped; drain 8 and refill -> pointers wrap, order preserved.
REQ-033 Flush: occupancy=5 with simultaneous push and issue_ready=11 -> next cycle occupancy=0, nothing issued from old or new entries.
